a2_timepulse: RTL and testbench

Time pulse generator sitting directly downstream of the A2 timer. It consumes the timer's ODDSET_ and EVNSET_ strobes and steps a one-hot ring through the twelve time pulses T01..T12 that make up one memory cycle time (MCT). It also produces an end-of-MCT strobe, a wrapping MCT count, and a sticky alarm when the odd/even strobe sequence breaks. The time pulses drive the downstream sequence and control logic.

---
 rtl/a2_timepulse.sv | 99 +++++++++
 tb/tb_a2_timepulse.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/a2_timepulse.sv
// Time pulse ring for the A2 timer: steps one-hot T01..T12 on alternating odd/even
// set strobes, counts completed memory cycle times and flags broken strobe sequences.
module a2_timepulse #(
  parameter int MCT_W = 8
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             ODDSET_,
  input  logic             EVNSET_,
  input  logic             STOP,
  input  logic             GOJAM,
  output logic [11:0]      TP,
  output logic [11:0]      TP_,
  output logic             EOMCT,
  output logic [MCT_W-1:0] MCTCNT,
  output logic             TPALM
);

  localparam logic [11:0] T12      = 12'h800;
  localparam logic [11:0] ODD_MASK = 12'h555;

  logic             prev_odd_q, prev_odd_d;
  logic             prev_evn_q, prev_evn_d;
  logic [11:0]      tp_q, tp_d;
  logic             eomct_q, eomct_d;
  logic [MCT_W-1:0] mctcnt_q, mctcnt_d;
  logic             tpalm_q, tpalm_d;

  logic        odd_ev, even_ev;
  logic        tp_legal, tp_is_odd, tp_is_even;
  logic [11:0] tp_next;

  assign odd_ev     = prev_odd_q & ~ODDSET_;
  assign even_ev    = prev_evn_q & ~EVNSET_;
  assign tp_legal   = (tp_q != 12'd0) && ((tp_q & (tp_q - 12'd1)) == 12'd0);
  assign tp_is_odd  = |(tp_q & ODD_MASK);
  assign tp_is_even = |(tp_q & ~ODD_MASK);
  assign tp_next    = {tp_q[10:0], tp_q[11]};

  always_comb begin
    prev_odd_d = ODDSET_;
    prev_evn_d = EVNSET_;
    tp_d       = tp_q;
    eomct_d    = 1'b0;
    mctcnt_d   = mctcnt_q;
    tpalm_d    = tpalm_q;
    if (GOJAM) begin
      tp_d     = T12;
      mctcnt_d = '0;
      tpalm_d  = 1'b0;
    end else if (!tp_legal) begin
      tp_d = T12;
    end else if (odd_ev && even_ev) begin
      tpalm_d = 1'b1;
    end else if (odd_ev) begin
      if (tp_is_even) begin
        tp_d = tp_next;
        if (tp_q[11]) begin
          eomct_d  = 1'b1;
          mctcnt_d = mctcnt_q + 1'b1;
        end
      end else begin
        tpalm_d = 1'b1;
      end
    end else if (even_ev) begin
      if (tp_is_odd) begin
        tp_d = tp_next;
      end else if (!STOP) begin
        // A missing odd strobe is expected while the timer is stopped.
        tpalm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      prev_odd_q <= 1'b1;
      prev_evn_q <= 1'b1;
      tp_q       <= T12;
      eomct_q    <= 1'b0;
      mctcnt_q   <= '0;
      tpalm_q    <= 1'b0;
    end else begin
      prev_odd_q <= prev_odd_d;
      prev_evn_q <= prev_evn_d;
      tp_q       <= tp_d;
      eomct_q    <= eomct_d;
      mctcnt_q   <= mctcnt_d;
      tpalm_q    <= tpalm_d;
    end
  end

  assign TP     = tp_q;
  assign TP_    = ~tp_q;
  assign EOMCT  = eomct_q;
  assign MCTCNT = mctcnt_q;
  assign TPALM  = tpalm_q;

endmodule

// File: tb/tb_a2_timepulse.sv
// Directed bench for a2_timepulse: strobe walks, alarms, STOP, wrap, GOJAM and async reset.
module tb_a2_timepulse;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST = 1'b0;
  logic        ODDSET_ = 1'b1;
  logic        EVNSET_ = 1'b1;
  logic        STOP    = 1'b0;
  logic        GOJAM   = 1'b0;
  logic [11:0] TP, TP_;
  logic        EOMCT;
  logic [7:0]  MCTCNT;
  logic        TPALM;

  int checks = 0;
  int errors = 0;

  always #5 SIM_CLK = ~SIM_CLK;

  a2_timepulse #(.MCT_W(8)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .ODDSET_(ODDSET_), .EVNSET_(EVNSET_),
    .STOP(STOP), .GOJAM(GOJAM), .TP(TP), .TP_(TP_), .EOMCT(EOMCT),
    .MCTCNT(MCTCNT), .TPALM(TPALM)
  );

  // One-cycle low pulse on the selected strobes; returns at the negedge after it was sampled.
  task automatic strobe(input bit odd, input bit even);
    @(negedge SIM_CLK);
    if (odd)  ODDSET_ = 1'b0;
    if (even) EVNSET_ = 1'b0;
    @(negedge SIM_CLK);
    ODDSET_ = 1'b1;
    EVNSET_ = 1'b1;
  endtask

  task automatic do_gojam();
    @(negedge SIM_CLK);
    GOJAM = 1'b1;
    @(negedge SIM_CLK);
    GOJAM = 1'b0;
  endtask

  task automatic test_reset();
    SIM_RST = 1'b0;
    repeat (2) @(negedge SIM_CLK);
    checks++; if (TP !== 12'h800)   begin errors++; $display("FAIL reset_tp got %h want 800", TP); end
    checks++; if (TP_ !== 12'h7FF)  begin errors++; $display("FAIL reset_tp_n got %h want 7ff", TP_); end
    checks++; if (EOMCT !== 1'b0)   begin errors++; $display("FAIL reset_eomct got %b want 0", EOMCT); end
    checks++; if (MCTCNT !== 8'd0)  begin errors++; $display("FAIL reset_mctcnt got %0d want 0", MCTCNT); end
    checks++; if (TPALM !== 1'b0)   begin errors++; $display("FAIL reset_tpalm got %b want 0", TPALM); end
    SIM_RST = 1'b1;
    repeat (2) @(negedge SIM_CLK);
  endtask

  task automatic test_walk();
    logic [11:0] exp_tp;
    int eom_seen = 0;
    for (int i = 0; i < 24; i++) begin
      strobe((i % 2) == 0, (i % 2) == 1);
      exp_tp = 12'h001 << (i % 12);
      checks++; if (TP !== exp_tp) begin errors++; $display("FAIL walk_tp step %0d got %h want %h", i, TP, exp_tp); end
      checks++; if (TP_ !== ~exp_tp) begin errors++; $display("FAIL walk_tp_n step %0d got %h want %h", i, TP_, ~exp_tp); end
      checks++; if (EOMCT !== ((i % 12) == 0)) begin errors++; $display("FAIL walk_eomct step %0d got %b", i, EOMCT); end
      if (EOMCT === 1'b1) eom_seen++;
    end
    checks++; if (eom_seen != 2)   begin errors++; $display("FAIL walk_eom_count got %0d want 2", eom_seen); end
    checks++; if (MCTCNT !== 8'd2) begin errors++; $display("FAIL walk_mctcnt got %0d want 2", MCTCNT); end
    checks++; if (TPALM !== 1'b0)  begin errors++; $display("FAIL walk_tpalm got %b want 0", TPALM); end
    @(negedge SIM_CLK);
    checks++; if (EOMCT !== 1'b0)  begin errors++; $display("FAIL walk_eomct_idle got %b want 0", EOMCT); end
  endtask

  task automatic test_hold_low();
    @(negedge SIM_CLK);
    ODDSET_ = 1'b0;
    @(negedge SIM_CLK);
    checks++; if (TP !== 12'h001) begin errors++; $display("FAIL hold_first_tp got %h want 001", TP); end
    repeat (4) @(negedge SIM_CLK);
    checks++; if (TP !== 12'h001)  begin errors++; $display("FAIL hold_tp got %h want 001", TP); end
    checks++; if (MCTCNT !== 8'd3) begin errors++; $display("FAIL hold_mctcnt got %0d want 3", MCTCNT); end
    ODDSET_ = 1'b1;
  endtask

  task automatic test_alarm();
    STOP = 1'b0;
    strobe(1'b1, 1'b0);
    checks++; if (TP !== 12'h001) begin errors++; $display("FAIL alarm_tp got %h want 001", TP); end
    checks++; if (TPALM !== 1'b1) begin errors++; $display("FAIL alarm_set got %b want 1", TPALM); end
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    checks++; if (TP !== 12'h004) begin errors++; $display("FAIL alarm_legal_tp got %h want 004", TP); end
    checks++; if (TPALM !== 1'b1) begin errors++; $display("FAIL alarm_sticky got %b want 1", TPALM); end
    do_gojam();
    checks++; if (TP !== 12'h800)  begin errors++; $display("FAIL alarm_gojam_tp got %h want 800", TP); end
    checks++; if (TPALM !== 1'b0)  begin errors++; $display("FAIL alarm_gojam_clr got %b want 0", TPALM); end
    checks++; if (MCTCNT !== 8'd0) begin errors++; $display("FAIL alarm_gojam_cnt got %0d want 0", MCTCNT); end
  endtask

  task automatic test_stop();
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b1);
    checks++; if (TP !== 12'h002) begin errors++; $display("FAIL stop_setup_tp got %h want 002", TP); end
    STOP = 1'b1;
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b1);
    checks++; if (TP !== 12'h002) begin errors++; $display("FAIL stop_tp got %h want 002", TP); end
    checks++; if (TPALM !== 1'b0) begin errors++; $display("FAIL stop_tpalm got %b want 0", TPALM); end
    STOP = 1'b0;
  endtask

  task automatic test_both();
    strobe(1'b1, 1'b0);
    checks++; if (TP !== 12'h004) begin errors++; $display("FAIL both_setup_tp got %h want 004", TP); end
    STOP = 1'b1;
    strobe(1'b1, 1'b1);
    STOP = 1'b0;
    checks++; if (TP !== 12'h004) begin errors++; $display("FAIL both_tp got %h want 004", TP); end
    checks++; if (TPALM !== 1'b1) begin errors++; $display("FAIL both_tpalm got %b want 1", TPALM); end
    do_gojam();
  endtask

  task automatic test_wrap();
    for (int m = 0; m < 256; m++) begin
      for (int s = 0; s < 12; s++) begin
        strobe((s % 2) == 0, (s % 2) == 1);
        if (s == 0 && m == 254) begin
          checks++; if (MCTCNT !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", MCTCNT); end
        end
        if (s == 0 && m == 255) begin
          checks++; if (MCTCNT !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", MCTCNT); end
          checks++; if (EOMCT !== 1'b1)  begin errors++; $display("FAIL wrap_eomct got %b want 1", EOMCT); end
        end
      end
    end
    checks++; if (TP !== 12'h800) begin errors++; $display("FAIL wrap_end_tp got %h want 800", TP); end
  endtask

  task automatic goto_t07();
    for (int s = 0; s < 7; s++) strobe((s % 2) == 0, (s % 2) == 1);
  endtask

  task automatic test_gojam();
    goto_t07();
    checks++; if (TP !== 12'h040)  begin errors++; $display("FAIL gojam_setup_tp got %h want 040", TP); end
    checks++; if (MCTCNT !== 8'd1) begin errors++; $display("FAIL gojam_setup_cnt got %0d want 1", MCTCNT); end
    strobe(1'b1, 1'b0);
    checks++; if (TPALM !== 1'b1)  begin errors++; $display("FAIL gojam_setup_alm got %b want 1", TPALM); end
    @(negedge SIM_CLK);
    GOJAM   = 1'b1;
    ODDSET_ = 1'b0;
    @(posedge SIM_CLK);
    #1;
    checks++; if (TP !== 12'h800)  begin errors++; $display("FAIL gojam_tp got %h want 800", TP); end
    checks++; if (MCTCNT !== 8'd0) begin errors++; $display("FAIL gojam_cnt got %0d want 0", MCTCNT); end
    checks++; if (TPALM !== 1'b0)  begin errors++; $display("FAIL gojam_alm got %b want 0", TPALM); end
    checks++; if (EOMCT !== 1'b0)  begin errors++; $display("FAIL gojam_eomct got %b want 0", EOMCT); end
    @(negedge SIM_CLK);
    GOJAM = 1'b0;
    @(negedge SIM_CLK);
    checks++; if (TP !== 12'h800) begin errors++; $display("FAIL gojam_discard got %h want 800", TP); end
    ODDSET_ = 1'b1;
  endtask

  task automatic test_reset_mid();
    goto_t07();
    checks++; if (TP !== 12'h040) begin errors++; $display("FAIL rstmid_setup_tp got %h want 040", TP); end
    #2;
    SIM_RST = 1'b0;
    #1;
    checks++; if (TP !== 12'h800)  begin errors++; $display("FAIL rstmid_tp got %h want 800", TP); end
    checks++; if (TP_ !== 12'h7FF) begin errors++; $display("FAIL rstmid_tp_n got %h want 7ff", TP_); end
    checks++; if (MCTCNT !== 8'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", MCTCNT); end
    checks++; if (EOMCT !== 1'b0)  begin errors++; $display("FAIL rstmid_eomct got %b want 0", EOMCT); end
    checks++; if (TPALM !== 1'b0)  begin errors++; $display("FAIL rstmid_alm got %b want 0", TPALM); end
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    repeat (2) @(negedge SIM_CLK);
    strobe(1'b1, 1'b0);
    checks++; if (TP !== 12'h001) begin errors++; $display("FAIL rstmid_resume got %h want 001", TP); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_hold_low();
    test_alarm();
    test_stop();
    test_both();
    test_wrap();
    test_gojam();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
